// File: rtl/program_loader_pkg.sv
// Shared CPU definitions: RAM geometry defaults and the program loader state encoding.
package program_loader_pkg;

    localparam int RAM_BYTES_DEF = 16;
    localparam int ADDR_W_DEF    = 4;

    typedef enum logic [2:0] {
        LD_IDLE     = 3'd0,
        LD_WAIT_STB = 3'd1,
        LD_WRITE    = 3'd2,
        LD_ACK      = 3'd3,
        LD_DONE     = 3'd4
    } loader_state_e;

    // States during which the CPU control block must be kept in reset.
    function automatic logic holds_cpu(input loader_state_e s);
        return (s == LD_WAIT_STB) || (s == LD_WRITE) || (s == LD_ACK);
    endfunction

endpackage

// File: rtl/program_loader_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a registered rising-edge pulse.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] stage_q;
    logic              rise_q;

    // The pulse is computed from the value about to enter the last stage, so it
    // is high in exactly the first cycle in which sync_o is high.
    always_ff @(posedge clk) begin
        if (clear) begin
            stage_q <= '0;
            rise_q  <= 1'b0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
            rise_q  <= stage_q[STAGES-2] & ~stage_q[STAGES-1];
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = rise_q;

endmodule

// File: rtl/program_loader.sv
// Host-driven byte loader for the CPU RAM: strobe handshake, address counter, CPU hold.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_BYTES   = RAM_BYTES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load_en,
    input  logic              strobe,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_we,
    output logic              ack,
    output logic              cpu_hold,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              ack_q, ack_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;

    logic stb_sync, stb_rise;
    logic len_sync;
    logic load_en_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strobe (
        .clk    (clk),
        .clear  (clear),
        .d_i    (strobe),
        .sync_o (stb_sync),
        .rise_o (stb_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load_en (
        .clk    (clk),
        .clear  (clear),
        .d_i    (load_en),
        .sync_o (len_sync),
        .rise_o (load_en_rise_unused)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Losing load_en takes priority over any strobe seen in the same cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            LD_IDLE: begin
                if (len_sync) state_d = LD_WAIT_STB;
            end
            LD_WAIT_STB: begin
                if (!len_sync) begin
                    state_d = LD_IDLE;
                end else if (stb_rise) begin
                    data_d  = data_in;
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                state_d = len_sync ? LD_ACK : LD_IDLE;
            end
            LD_ACK: begin
                if (!len_sync) begin
                    state_d = LD_IDLE;
                end else if (!stb_sync) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = LD_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = LD_WAIT_STB;
                    end
                end
            end
            LD_DONE: begin
                if (!len_sync) state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
        if (state_d == LD_IDLE) addr_d = '0;
    end

    // Handshake outputs track the next state; cpu_hold deliberately lags one cycle.
    always_comb begin
        we_d   = (state_d == LD_WRITE);
        ack_d  = (state_d == LD_ACK);
        done_d = (state_d == LD_DONE);
        hold_d = holds_cpu(state_q);
    end

    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign ram_we   = we_q;
    assign ack      = ack_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard fed by the stimulus.
module tb_program_loader;
    import program_loader_pkg::*;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       clear;
    logic       load_en;
    logic       strobe;
    logic [7:0] data_in;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       ack;
    logic       cpu_hold;
    logic       done;

    int         total = 0;
    int         bad = 0;
    int         we_count = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [3:0] exp_addr;
    logic       ack_seen;

    always #5 clk = ~clk;

    program_loader dut (
        .clk      (clk),
        .clear    (clear),
        .load_en  (load_en),
        .strobe   (strobe),
        .data_in  (data_in),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ack      (ack),
        .cpu_hold (cpu_hold),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic level, input string tag);
        int n = 0;
        while (ack !== level && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, ack}, {31'd0, level});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic expect_w);
        if (expect_w) exp_q.push_back(wr_t'{exp_addr, d});
        data_in = d;
        strobe  = 1'b1;
        wait_ack(1'b1, "ack_rise");
        check("hold_in_load", {31'd0, cpu_hold}, 32'd1);
        strobe = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    // Scoreboard: every write pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_count++;
            $display("write addr=%0d data=%02h pending=%0d", ram_addr, ram_data, exp_q.size());
            check("we_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("we_addr", {28'd0, ram_addr}, {28'd0, mon_e.addr});
                check("we_data", {24'd0, ram_data}, {24'd0, mon_e.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear   = 1'b1;
        load_en = 1'b1;
        strobe  = 1'b1;
        data_in = 8'h55;
        exp_addr = 4'd0;
        tick(2);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_data", {24'd0, ram_data}, 32'd0);
        check("rst_we",   {31'd0, ram_we},   32'd0);
        check("rst_ack",  {31'd0, ack},      32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, done},     32'd0);
        load_en = 1'b0;
        strobe  = 1'b0;
        tick(3);
        clear = 1'b0;
        tick(3);
        check("idle_hold", {31'd0, cpu_hold}, 32'd0);
        check("idle_no_we", we_count, 0);

        // Full load; the first byte also measures latencies.
        load_en = 1'b1;
        tick(3);
        check("hold_lag", {31'd0, cpu_hold}, 32'd0);
        tick(1);
        check("hold_rise", {31'd0, cpu_hold}, 32'd1);
        exp_addr = 4'd0;
        exp_q.push_back(wr_t'{4'd0, 8'h10});
        data_in = 8'h10;
        strobe  = 1'b1;
        tick(2);
        check("lat_we_early", {31'd0, ram_we}, 32'd0);
        tick(1);
        check("lat_we", {31'd0, ram_we}, 32'd1);
        tick(1);
        check("ack_after_write", {31'd0, ack}, 32'd1);
        check("we_one_cycle", {31'd0, ram_we}, 32'd0);
        tick(10);
        check("held_strobe_one_write", we_count, 1);
        strobe = 1'b0;
        tick(2);
        check("ack_still_high", {31'd0, ack}, 32'd1);
        tick(1);
        check("ack_fall_lat", {31'd0, ack}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            exp_addr = i[3:0];
            send_byte(8'h10 + i[7:0], 1'b1);
        end
        check("done_set", {31'd0, done}, 32'd1);
        check("hold_fall_lag", {31'd0, cpu_hold}, 32'd1);
        tick(1);
        check("hold_after_done", {31'd0, cpu_hold}, 32'd0);
        check("full_we_count", we_count, 16);
        check("full_queue_empty", exp_q.size(), 0);

        // Overrun: a 17th strobe in DONE is ignored.
        data_in  = 8'hAA;
        strobe   = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ack === 1'b1) ack_seen = 1'b1;
        end
        strobe = 1'b0;
        tick(4);
        check("overrun_ack", {31'd0, ack_seen}, 32'd0);
        check("overrun_we", we_count, 16);
        check("overrun_done", {31'd0, done}, 32'd1);

        // Leave DONE, load 5 bytes, abort, restart at address 0.
        load_en = 1'b0;
        tick(4);
        check("done_cleared", {31'd0, done}, 32'd0);
        check("idle_hold_after_done", {31'd0, cpu_hold}, 32'd0);
        load_en = 1'b1;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            exp_addr = i[3:0];
            send_byte(8'h20 + i[7:0], 1'b1);
        end
        load_en = 1'b0;
        tick(5);
        check("abort_hold", {31'd0, cpu_hold}, 32'd0);
        check("abort_ack",  {31'd0, ack},      32'd0);
        check("abort_done", {31'd0, done},     32'd0);
        check("abort_we",   we_count, 21);
        load_en = 1'b1;
        tick(4);
        exp_addr = 4'd0;
        send_byte(8'h30, 1'b1);
        check("restart_we", we_count, 22);

        // Race: load_en fall and strobe rise synchronize together.
        load_en = 1'b0;
        strobe  = 1'b1;
        data_in = 8'h5A;
        tick(8);
        check("race_we",   we_count, 22);
        check("race_hold", {31'd0, cpu_hold}, 32'd0);
        check("race_ack",  {31'd0, ack},      32'd0);
        strobe = 1'b0;
        tick(3);
        load_en = 1'b1;
        tick(4);
        exp_addr = 4'd0;
        send_byte(8'h3C, 1'b1);

        // Clear during a write cycle.
        exp_addr = 4'd1;
        exp_q.push_back(wr_t'{4'd1, 8'h77});
        data_in = 8'h77;
        strobe  = 1'b1;
        tick(3);
        check("mid_we", {31'd0, ram_we}, 32'd1);
        clear = 1'b1;
        tick(1);
        check("clr_we",   {31'd0, ram_we},   32'd0);
        check("clr_ack",  {31'd0, ack},      32'd0);
        check("clr_hold", {31'd0, cpu_hold}, 32'd0);
        check("clr_addr", {28'd0, ram_addr}, 32'd0);
        check("clr_data", {24'd0, ram_data}, 32'd0);
        strobe  = 1'b0;
        load_en = 1'b0;
        tick(2);
        clear = 1'b0;
        tick(3);
        check("end_queue_empty", exp_q.size(), 0);
        check("end_we_count", we_count, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
